mf_capture_buffer: RTL and testbench
====================================

Name: mf_capture_buffer

Overview:
- Synthesizable capture store that writes a complex sample stream into on-chip RAM, then plays it back on request.
- It performs the write-side counterpart of setup_MF_coeff, which reads MIF data and streams it out; this block takes a stream in and stores it.
- Sits after the matched filter. It captures up to LENGTH Re/Im samples for later readout to a host or debug interface.
- Readout format matches setup_MF_coeff: outputRe/outputIm plus dataFinishedFlag.

Parameters:
- LENGTH, 33000, number of complex samples stored (RAM depth).
- DATA_WIDTH, 16, bit width of each real and each imaginary sample, signed.
- ADDR_WIDTH, 16, address/counter width; must satisfy 2^ADDR_WIDTH >= LENGTH+1.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  level; rising from IDLE arms a capture; low in FINISHED returns the block to IDLE.
- inputValid  in  1  inputRe/inputIm are valid this cycle.
- inputRe  in  DATA_WIDTH  signed real input sample.
- inputIm  in  DATA_WIDTH  signed imaginary input sample.
- readEnable  in  1  level; requests one read per cycle while high in DONE/READOUT.
- captureDoneFlag  out  1  capture complete, RAM contents stable.
- sampleCount  out  ADDR_WIDTH  number of samples captured.
- outputValid  out  1  outputRe/outputIm carry a stored sample.
- outputRe  out  DATA_WIDTH  signed real readout sample.
- outputIm  out  DATA_WIDTH  signed imaginary readout sample.
- dataFinishedFlag  out  1  all captured samples have been read out.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; writeAddr, readAddr, sampleCount = 0; all flags, outputValid, outputRe and outputIm = 0. RAM contents are not cleared.
- All outputs are registered. RAM has a 1-cycle synchronous read (inferable M9K/M10K).
- IDLE:
  - enable=1 -> CAPTURE, writeAddr=0. Input samples arriving in the IDLE cycle are ignored.
- CAPTURE:
  - inputValid=1 -> write {inputRe,inputIm} to mem[writeAddr]; writeAddr++; sampleCount=writeAddr+1.
  - inputValid=0 cycles write nothing; gaps are allowed.
  - Write at writeAddr=LENGTH-1 -> DONE on the next edge; captureDoneFlag=1; sampleCount=LENGTH.
  - enable=0 in CAPTURE -> DONE immediately with a partial sampleCount. A sample valid in that same cycle is NOT written.
  - Overflow is impossible: no write occurs outside CAPTURE. inputValid in DONE/READOUT/FINISHED is ignored.
- DONE:
  - captureDoneFlag=1 and held until the return to IDLE.
  - readEnable=1 and sampleCount>0 -> READOUT, readAddr=0.
  - readEnable=1 and sampleCount=0 -> FINISHED directly; no outputValid pulse.
- READOUT:
  - Each cycle with readEnable=1 issues a read of mem[readAddr] and increments readAddr.
  - Data appears on outputRe/outputIm with outputValid=1 exactly one cycle after issue.
  - readEnable=0 pauses: no issue, and outputValid=0 the following cycle. Output data holds its last value.
  - The read issued at readAddr=sampleCount-1 is the last. The state moves to FINISHED on the same edge that presents the last sample.
- FINISHED:
  - dataFinishedFlag=1 from the cycle after the last outputValid; held high.
  - enable=0 -> IDLE on the next edge; clears captureDoneFlag, dataFinishedFlag and sampleCount.
  - Re-arming requires enable low then high.
- Simultaneous events:
  - enable low together with readEnable in DONE: readout proceeds; enable is only acted on in CAPTURE and FINISHED.
  - Reset mid-capture or mid-readout: immediate return to IDLE with all outputs zeroed.
- Arithmetic: no scaling, rounding or sign manipulation; data are stored and returned bit-exact.

Test Plan (bench with LENGTH=8, DATA_WIDTH=16):
1. Reset held 10 cycles, then released with enable=0 -> all outputs 0, state IDLE, no writes.
2. Full capture then full readout:
   - Stimulus: enable=1; 8 back-to-back samples Re=k, Im=-k for k=1..8.
   - Capture response: captureDoneFlag=1, sampleCount=8.
   - Readout: readEnable=1 for 8 cycles -> outputValid for 8 consecutive cycles starting 1 cycle after the first request, values (1,-1)..(8,-8).
   - Finish: dataFinishedFlag=1 one cycle after the last sample.
3. Gapped input and paused readout:
   - Stimulus: inputValid alternating 1/0 with values 100..107; readEnable toggling 1,1,0,1,...
   - Response: the stored order is preserved; outputValid is low exactly one cycle after each readEnable=0 cycle; no sample is duplicated or skipped.
4. Early stop:
   - Stimulus: capture 3 samples (5,6,7), then enable=0 alongside a valid sample 9.
   - Response: sampleCount=3, sample 9 is not stored, and readout returns exactly 5,6,7 then dataFinishedFlag.
5. Zero-length capture:
   - Stimulus: enable pulses high 1 cycle with no inputValid, then readEnable=1.
   - Response: sampleCount=0, FINISHED with no outputValid, dataFinishedFlag=1.
6. Reset mid-readout and re-arm:
   - Stimulus: assert reset=0 after the 4th output sample; release reset; enable=1 and capture 8 new samples (200..207).
   - Response: flags clear asynchronously on reset; the second capture reads back 200..207 correctly.

Source files
------------

// File: rtl/mf_capture_buffer.sv
// Capture store: writes a complex Re/Im sample stream into on-chip RAM, then
// plays it back on request with outputRe/outputIm/outputValid and a finished flag.
module mf_capture_buffer #(
  parameter int LENGTH     = 33000,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         inputValid,
  input  logic signed [DATA_WIDTH-1:0] inputRe,
  input  logic signed [DATA_WIDTH-1:0] inputIm,
  input  logic                         readEnable,
  output logic                         captureDoneFlag,
  output logic        [ADDR_WIDTH-1:0] sampleCount,
  output logic                         outputValid,
  output logic signed [DATA_WIDTH-1:0] outputRe,
  output logic signed [DATA_WIDTH-1:0] outputIm,
  output logic                         dataFinishedFlag
);

  localparam int MEM_AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE,
    S_READOUT,
    S_FINISHED
  } state_t;

  state_t                         r_state;
  logic        [ADDR_WIDTH-1:0]   r_waddr;
  logic        [ADDR_WIDTH-1:0]   r_raddr;
  logic        [ADDR_WIDTH-1:0]   r_count;
  logic                           r_done;
  logic                           r_valid;
  logic                           r_finished;
  logic signed [DATA_WIDTH-1:0]   r_re;
  logic signed [DATA_WIDTH-1:0]   r_im;
  logic        [2*DATA_WIDTH-1:0] r_mem [LENGTH];

  logic                           w_wr;
  logic                           w_last_wr;
  logic                           w_last_rd;
  logic        [ADDR_WIDTH-1:0]   w_rd_addr;
  logic        [2*DATA_WIDTH-1:0] w_rd_word;

  assign w_wr      = (r_state == S_CAPTURE) && enable && inputValid;
  assign w_last_wr = (r_waddr == ADDR_WIDTH'(LENGTH - 1));
  // The first read is issued from DONE itself, always at address 0.
  assign w_rd_addr = (r_state == S_DONE) ? '0 : r_raddr;
  assign w_last_rd = (w_rd_addr == (r_count - 1'b1));
  assign w_rd_word = r_mem[w_rd_addr[MEM_AW-1:0]];

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_waddr[MEM_AW-1:0]] <= {inputRe, inputIm};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_waddr    <= '0;
      r_raddr    <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_finished <= 1'b0;
      r_re       <= '0;
      r_im       <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_CAPTURE;
            r_waddr <= '0;
          end
        end
        S_CAPTURE: begin
          if (!enable) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (inputValid) begin
            r_waddr <= r_waddr + 1'b1;
            r_count <= r_waddr + 1'b1;
            if (w_last_wr) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE, S_READOUT: begin
          if (readEnable) begin
            if ((r_state == S_DONE) && (r_count == '0)) begin
              r_state <= S_FINISHED;
            end else begin
              r_re    <= $signed(w_rd_word[2*DATA_WIDTH-1:DATA_WIDTH]);
              r_im    <= $signed(w_rd_word[DATA_WIDTH-1:0]);
              r_valid <= 1'b1;
              r_raddr <= w_rd_addr + 1'b1;
              r_state <= w_last_rd ? S_FINISHED : S_READOUT;
            end
          end
        end
        S_FINISHED: begin
          // The finished flag is always visible for at least one cycle before leaving.
          if (!r_finished) begin
            r_finished <= 1'b1;
          end else if (!enable) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_finished <= 1'b0;
            r_count    <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign captureDoneFlag  = r_done;
  assign sampleCount      = r_count;
  assign outputValid      = r_valid;
  assign outputRe         = r_re;
  assign outputIm         = r_im;
  assign dataFinishedFlag = r_finished;

endmodule

// File: tb/tb_mf_capture_buffer.sv
// Directed bench for mf_capture_buffer with LENGTH=8: capture, gapped readout,
// early stop, zero-length capture, and asynchronous reset mid-readout.
module tb_mf_capture_buffer;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic               inputValid;
  logic signed [15:0] inputRe;
  logic signed [15:0] inputIm;
  logic               readEnable;
  logic               captureDoneFlag;
  logic        [15:0] sampleCount;
  logic               outputValid;
  logic signed [15:0] outputRe;
  logic signed [15:0] outputIm;
  logic               dataFinishedFlag;

  int total = 0;
  int bad   = 0;

  mf_capture_buffer #(.LENGTH(8), .DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clock           (clk),
    .reset           (rst_n),
    .enable          (enable),
    .inputValid      (inputValid),
    .inputRe         (inputRe),
    .inputIm         (inputIm),
    .readEnable      (readEnable),
    .captureDoneFlag (captureDoneFlag),
    .sampleCount     (sampleCount),
    .outputValid     (outputValid),
    .outputRe        (outputRe),
    .outputIm        (outputIm),
    .dataFinishedFlag(dataFinishedFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_flags(input string tag, input int done, input int cnt, input int vld, input int fin);
    chk({tag, ".done"}, 32'(captureDoneFlag), done);
    chk({tag, ".count"}, 32'(sampleCount), cnt);
    chk({tag, ".valid"}, 32'(outputValid), vld);
    chk({tag, ".finished"}, 32'(dataFinishedFlag), fin);
  endtask

  task automatic chk_sample(input string tag, input int re, input int im);
    chk({tag, ".valid"}, 32'(outputValid), 1);
    chk({tag, ".re"}, 32'(outputRe), re);
    chk({tag, ".im"}, 32'(outputIm), im);
  endtask

  task automatic drive(input logic v, input int re, input int im);
    inputValid = v;
    inputRe    = 16'(re);
    inputIm    = 16'(im);
  endtask

  int issued;
  int last_re;
  logic re_pat [3];

  initial begin
    rst_n = 1'b0; enable = 1'b0; readEnable = 1'b0;
    drive(1'b0, 0, 0);

    // 1. reset
    repeat (10) tick();
    chk_flags("rst", 0, 0, 0, 0);
    chk("rst.re", 32'(outputRe), 0);
    chk("rst.im", 32'(outputIm), 0);
    rst_n = 1'b1;
    tick();
    chk_flags("idle", 0, 0, 0, 0);

    // 2. full capture then full readout
    enable = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, k, -k);
      tick();
      if (k == 1) chk("cap.count1", 32'(sampleCount), 1);
      if (k == 7) chk("cap.notdone7", 32'(captureDoneFlag), 0);
    end
    drive(1'b0, 0, 0);
    chk_flags("cap.full", 1, 8, 0, 0);
    tick();
    chk_flags("cap.hold", 1, 8, 0, 0);
    readEnable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_sample($sformatf("rd.full%0d", k), k, -k);
      chk("rd.fin_low", 32'(dataFinishedFlag), 0);
    end
    readEnable = 1'b0;
    tick();
    chk_flags("rd.finish", 1, 8, 0, 1);
    chk("rd.hold_re", 32'(outputRe), 8);
    tick();
    chk("rd.finish_held", 32'(dataFinishedFlag), 1);
    enable = 1'b0;
    tick();
    chk_flags("back_idle", 0, 0, 0, 0);

    // 3. gapped input, paused readout
    enable = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 100 + j, 1000 + j);
      tick();
      drive(1'b0, 999, 999);
      tick();
    end
    chk_flags("gap.cap", 1, 8, 0, 0);
    re_pat[0] = 1'b1; re_pat[1] = 1'b1; re_pat[2] = 1'b0;
    issued = 0;
    last_re = 0;
    for (int c = 0; c < 40 && issued < 8; c++) begin
      readEnable = re_pat[c % 3];
      tick();
      if (re_pat[c % 3]) begin
        chk_sample($sformatf("gap.rd%0d", issued), 100 + issued, 1000 + issued);
        last_re = 100 + issued;
        issued++;
      end else begin
        chk("gap.pause_valid", 32'(outputValid), 0);
        chk("gap.pause_hold", 32'(outputRe), last_re);
      end
    end
    chk("gap.issued", issued, 8);
    readEnable = 1'b0;
    tick();
    chk_flags("gap.finish", 1, 8, 0, 1);
    enable = 1'b0;
    tick();
    chk_flags("gap.idle", 0, 0, 0, 0);

    // 4. early stop; sample 9 must not be stored
    enable = 1'b1;
    tick();
    for (int k = 5; k <= 7; k++) begin
      drive(1'b1, k, -k);
      tick();
    end
    enable = 1'b0;
    drive(1'b1, 9, -9);
    tick();
    drive(1'b0, 0, 0);
    chk_flags("early.cap", 1, 3, 0, 0);
    readEnable = 1'b1;
    for (int k = 5; k <= 7; k++) begin
      tick();
      chk_sample($sformatf("early.rd%0d", k), k, -k);
    end
    tick();
    chk_flags("early.finish", 1, 3, 0, 1);
    readEnable = 1'b0;
    tick();
    chk_flags("early.idle", 0, 0, 0, 0);

    // 5. zero-length capture
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    chk_flags("zero.cap", 1, 0, 0, 0);
    readEnable = 1'b1;
    tick();
    chk_flags("zero.fin_entry", 1, 0, 0, 0);
    readEnable = 1'b0;
    tick();
    chk_flags("zero.finish", 1, 0, 0, 1);
    tick();
    chk_flags("zero.idle", 0, 0, 0, 0);

    // 6. reset mid-readout, then re-arm; arming-cycle sample is ignored
    enable = 1'b1;
    drive(1'b1, 55, 55);
    tick();
    drive(1'b0, 0, 0);
    chk("arm.ignored", 32'(sampleCount), 0);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 10 + k, -10 - k);
      tick();
    end
    drive(1'b0, 0, 0);
    chk_flags("pre.cap", 1, 8, 0, 0);
    readEnable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_sample($sformatf("pre.rd%0d", k), 10 + k, -10 - k);
    end
    rst_n = 1'b0;
    readEnable = 1'b0;
    #1;
    chk_flags("async_rst", 0, 0, 0, 0);
    chk("async_rst.re", 32'(outputRe), 0);
    chk("async_rst.im", 32'(outputIm), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 200 + k, -200 - k);
      tick();
    end
    drive(1'b0, 0, 0);
    chk_flags("rearm.cap", 1, 8, 0, 0);
    readEnable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_sample($sformatf("rearm.rd%0d", k), 200 + k, -200 - k);
    end
    readEnable = 1'b0;
    tick();
    chk_flags("rearm.finish", 1, 8, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
